issue_scoreboard: RTL and testbench

- In-order issue stage between Decode and Execute.
- Holds one decoded instruction and tracks outstanding register writes in a per-register scoreboard.
- Stalls Fetch/Decode through is_if_stall until the instruction's source operands are written back.
- Reads the operands from the register file in the cycle it dispatches, then drives a registered, valid/ready-handshaked bundle to Execute.

---
 rtl/issue_scoreboard.sv | 193 +++++++++++++++++++
 tb/tb_issue_scoreboard.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_scoreboard.sv
// rtl/issue_scoreboard.sv - in-order issue stage: holds one decoded instruction, blocks it on
// outstanding register writes tracked by per-register counters, and dispatches a registered bundle.
module issue_scoreboard #(
   parameter int PEND_W = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        id_is_valid,
   input  logic [4:0]  id_is_addra,
   input  logic [4:0]  id_is_addrb,
   input  logic [1:0]  id_is_numop,
   input  logic        id_is_selalushift,
   input  logic        id_is_selimregb,
   input  logic        id_is_unsig,
   input  logic        id_is_readmem,
   input  logic        id_is_writemem,
   input  logic        id_is_selwsource,
   input  logic        id_is_writereg,
   input  logic        id_is_writeov,
   input  logic [2:0]  id_is_aluop,
   input  logic [1:0]  id_is_shiftop,
   input  logic [4:0]  id_is_regdest,
   input  logic [31:0] id_is_imedext,
   output logic        is_if_stall,
   output logic [4:0]  is_reg_addra,
   output logic [4:0]  is_reg_addrb,
   input  logic [31:0] reg_is_dataa,
   input  logic [31:0] reg_is_datab,
   input  logic        wb_is_writereg,
   input  logic [4:0]  wb_is_regdest,
   output logic        is_ex_valid,
   input  logic        ex_is_ready,
   output logic        is_ex_selalushift,
   output logic        is_ex_selimregb,
   output logic        is_ex_unsig,
   output logic        is_ex_readmem,
   output logic        is_ex_writemem,
   output logic        is_ex_selwsource,
   output logic        is_ex_writereg,
   output logic        is_ex_writeov,
   output logic [2:0]  is_ex_aluop,
   output logic [1:0]  is_ex_shiftop,
   output logic [4:0]  is_ex_regdest,
   output logic [31:0] is_ex_imedext,
   output logic [31:0] is_ex_rega,
   output logic [31:0] is_ex_regb,
   output logic [4:0]  is_ex_shiftamt,
   output logic        is_sb_error
);

   localparam logic [PEND_W-1:0] CNT_MAX = '1;
   localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

   logic        hv;
   logic [4:0]  h_addra;
   logic [4:0]  h_addrb;
   logic [1:0]  h_numop;
   logic        h_selalushift;
   logic        h_selimregb;
   logic        h_unsig;
   logic        h_readmem;
   logic        h_writemem;
   logic        h_selwsource;
   logic        h_writereg;
   logic        h_writeov;
   logic [2:0]  h_aluop;
   logic [1:0]  h_shiftop;
   logic [4:0]  h_regdest;
   logic [31:0] h_imedext;

   logic [PEND_W-1:0] cnt [32];

   logic hazard;
   logic out_free;
   logic dispatch;
   logic inc;
   logic dec;
   logic inc_dec_same;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hv            <= 1'b0;
         h_addra       <= '0;
         h_addrb       <= '0;
         h_numop       <= '0;
         h_selalushift <= 1'b0;
         h_selimregb   <= 1'b0;
         h_unsig       <= 1'b0;
         h_readmem     <= 1'b0;
         h_writemem    <= 1'b0;
         h_selwsource  <= 1'b0;
         h_writereg    <= 1'b0;
         h_writeov     <= 1'b0;
         h_aluop       <= '0;
         h_shiftop     <= '0;
         h_regdest     <= '0;
         h_imedext     <= '0;
      end else if (!is_if_stall) begin
         hv            <= id_is_valid;
         h_addra       <= id_is_addra;
         h_addrb       <= id_is_addrb;
         h_numop       <= id_is_numop;
         h_selalushift <= id_is_selalushift;
         h_selimregb   <= id_is_selimregb;
         h_unsig       <= id_is_unsig;
         h_readmem     <= id_is_readmem;
         h_writemem    <= id_is_writemem;
         h_selwsource  <= id_is_selwsource;
         h_writereg    <= id_is_writereg;
         h_writeov     <= id_is_writeov;
         h_aluop       <= id_is_aluop;
         h_shiftop     <= id_is_shiftop;
         h_regdest     <= id_is_regdest;
         h_imedext     <= id_is_imedext;
      end
   end

   // Registered counts only: a writeback frees its dependants one cycle later, once the
   // register file already returns the new value.
   always_comb begin
      hazard = 1'b0;
      if (h_numop != 2'd0 && cnt[h_addra] != '0) hazard = 1'b1;
      if (h_numop == 2'd2 && cnt[h_addrb] != '0) hazard = 1'b1;
      if (h_writereg && h_regdest != 5'd0 && cnt[h_regdest] == CNT_MAX) hazard = 1'b1;
   end

   assign out_free     = !is_ex_valid || ex_is_ready;
   assign dispatch     = hv && !hazard && out_free;
   assign is_if_stall  = hv && !dispatch;
   assign is_reg_addra = h_addra;
   assign is_reg_addrb = h_addrb;

   assign inc          = dispatch && h_writereg && h_regdest != 5'd0;
   assign dec          = wb_is_writereg && wb_is_regdest != 5'd0;
   assign inc_dec_same = inc && dec && h_regdest == wb_is_regdest;

   // cnt[0] is only ever written by reset, so register 0 never looks pending.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int r = 0; r < 32; r++) cnt[r] <= '0;
         is_sb_error <= 1'b0;
      end else begin
         for (int r = 1; r < 32; r++) begin
            if (inc && !inc_dec_same && h_regdest == 5'(r))
               cnt[r] <= cnt[r] + CNT_ONE;
            else if (dec && !inc_dec_same && wb_is_regdest == 5'(r) && cnt[r] != '0)
               cnt[r] <= cnt[r] - CNT_ONE;
         end
         if (dec && !inc_dec_same && cnt[wb_is_regdest] == '0) is_sb_error <= 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         is_ex_valid       <= 1'b0;
         is_ex_selalushift <= 1'b0;
         is_ex_selimregb   <= 1'b0;
         is_ex_unsig       <= 1'b0;
         is_ex_readmem     <= 1'b0;
         is_ex_writemem    <= 1'b0;
         is_ex_selwsource  <= 1'b0;
         is_ex_writereg    <= 1'b0;
         is_ex_writeov     <= 1'b0;
         is_ex_aluop       <= '0;
         is_ex_shiftop     <= '0;
         is_ex_regdest     <= '0;
         is_ex_imedext     <= '0;
         is_ex_rega        <= '0;
         is_ex_regb        <= '0;
         is_ex_shiftamt    <= '0;
      end else if (dispatch) begin
         is_ex_valid       <= 1'b1;
         is_ex_selalushift <= h_selalushift;
         is_ex_selimregb   <= h_selimregb;
         is_ex_unsig       <= h_unsig;
         is_ex_readmem     <= h_readmem;
         is_ex_writemem    <= h_writemem;
         is_ex_selwsource  <= h_selwsource;
         is_ex_writereg    <= h_writereg;
         is_ex_writeov     <= h_writeov;
         is_ex_aluop       <= h_aluop;
         is_ex_shiftop     <= h_shiftop;
         is_ex_regdest     <= h_regdest;
         is_ex_imedext     <= h_imedext;
         is_ex_rega        <= reg_is_dataa;
         is_ex_regb        <= reg_is_datab;
         is_ex_shiftamt    <= reg_is_dataa[4:0];
      end else if (ex_is_ready) begin
         is_ex_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_issue_scoreboard.sv
// tb/tb_issue_scoreboard.sv - directed bench for issue_scoreboard with a behavioural model
module tb_issue_scoreboard;

   localparam int PEND_W = 2;
   localparam int CMAX   = (1 << PEND_W) - 1;

   typedef struct packed {
      logic        valid;
      logic [4:0]  addra;
      logic [4:0]  addrb;
      logic [1:0]  numop;
      logic        selalushift;
      logic        selimregb;
      logic        unsig;
      logic        readmem;
      logic        writemem;
      logic        selwsource;
      logic        writereg;
      logic        writeov;
      logic [2:0]  aluop;
      logic [1:0]  shiftop;
      logic [4:0]  regdest;
      logic [31:0] imedext;
   } id_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   id_t         id_in = '0;
   logic        ex_is_ready = 1'b1;
   logic        wb_is_writereg = 1'b0;
   logic [4:0]  wb_is_regdest = '0;
   logic [31:0] wb_data = '0;

   logic        is_if_stall;
   logic [4:0]  is_reg_addra, is_reg_addrb;
   logic [31:0] reg_is_dataa, reg_is_datab;
   logic        is_ex_valid;
   logic        is_ex_selalushift, is_ex_selimregb, is_ex_unsig, is_ex_readmem;
   logic        is_ex_writemem, is_ex_selwsource, is_ex_writereg, is_ex_writeov;
   logic [2:0]  is_ex_aluop;
   logic [1:0]  is_ex_shiftop;
   logic [4:0]  is_ex_regdest, is_ex_shiftamt;
   logic [31:0] is_ex_imedext, is_ex_rega, is_ex_regb;
   logic        is_sb_error;

   int checks = 0;
   int errors = 0;

   issue_scoreboard #(.PEND_W(PEND_W)) dut (
      .clock(clock), .reset(reset),
      .id_is_valid(id_in.valid), .id_is_addra(id_in.addra), .id_is_addrb(id_in.addrb),
      .id_is_numop(id_in.numop), .id_is_selalushift(id_in.selalushift),
      .id_is_selimregb(id_in.selimregb), .id_is_unsig(id_in.unsig),
      .id_is_readmem(id_in.readmem), .id_is_writemem(id_in.writemem),
      .id_is_selwsource(id_in.selwsource), .id_is_writereg(id_in.writereg),
      .id_is_writeov(id_in.writeov), .id_is_aluop(id_in.aluop),
      .id_is_shiftop(id_in.shiftop), .id_is_regdest(id_in.regdest),
      .id_is_imedext(id_in.imedext),
      .is_if_stall(is_if_stall), .is_reg_addra(is_reg_addra), .is_reg_addrb(is_reg_addrb),
      .reg_is_dataa(reg_is_dataa), .reg_is_datab(reg_is_datab),
      .wb_is_writereg(wb_is_writereg), .wb_is_regdest(wb_is_regdest),
      .is_ex_valid(is_ex_valid), .ex_is_ready(ex_is_ready),
      .is_ex_selalushift(is_ex_selalushift), .is_ex_selimregb(is_ex_selimregb),
      .is_ex_unsig(is_ex_unsig), .is_ex_readmem(is_ex_readmem),
      .is_ex_writemem(is_ex_writemem), .is_ex_selwsource(is_ex_selwsource),
      .is_ex_writereg(is_ex_writereg), .is_ex_writeov(is_ex_writeov),
      .is_ex_aluop(is_ex_aluop), .is_ex_shiftop(is_ex_shiftop),
      .is_ex_regdest(is_ex_regdest), .is_ex_imedext(is_ex_imedext),
      .is_ex_rega(is_ex_rega), .is_ex_regb(is_ex_regb), .is_ex_shiftamt(is_ex_shiftamt),
      .is_sb_error(is_sb_error)
   );

   always #5 clock = ~clock;

   // Register file stand-in: written by the writeback strobe, read combinationally.
   logic [31:0] rf [32];
   always @(posedge clock) begin
      if (!reset) begin
         for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'h0 : 32'hA500_0000 + 32'(i) * 32'h0001_0101;
      end else if (wb_is_writereg && wb_is_regdest != 5'd0) begin
         rf[wb_is_regdest] <= wb_data;
      end
   end
   assign reg_is_dataa = rf[is_reg_addra];
   assign reg_is_datab = rf[is_reg_addrb];

   // Behavioural model: pending-write counts per register, one held instruction, one output slot.
   id_t         m_hold = '0;
   id_t         m_ex = '0;
   logic [31:0] m_rega = '0, m_regb = '0;
   logic [4:0]  m_shamt = '0;
   bit          m_exv = 1'b0;
   bit          m_err = 1'b0;
   int          m_cnt [32];
   bit          md;
   int          mdelta;

   function automatic bit m_hazard();
      return (m_hold.numop >= 2'd1 && m_cnt[m_hold.addra] != 0) ||
             (m_hold.numop == 2'd2 && m_cnt[m_hold.addrb] != 0) ||
             (m_hold.writereg && m_hold.regdest != 5'd0 && m_cnt[m_hold.regdest] == CMAX);
   endfunction

   function automatic bit m_dispatch();
      return m_hold.valid && !m_hazard() && (!m_exv || ex_is_ready);
   endfunction

   function automatic bit m_stall();
      return m_hold.valid && !m_dispatch();
   endfunction

   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         m_hold = '0;
         m_ex   = '0;
         m_rega = '0;
         m_regb = '0;
         m_shamt = '0;
         m_exv  = 1'b0;
         m_err  = 1'b0;
         foreach (m_cnt[i]) m_cnt[i] = 0;
      end else begin
         md = m_dispatch();
         if (md) begin
            m_ex    = m_hold;
            m_rega  = rf[m_hold.addra];
            m_regb  = rf[m_hold.addrb];
            m_shamt = m_rega[4:0];
            m_exv   = 1'b1;
         end else if (ex_is_ready) begin
            m_exv = 1'b0;
         end
         for (int r = 1; r < 32; r++) begin
            mdelta = ((md && m_hold.writereg && m_hold.regdest == 5'(r)) ? 1 : 0) -
                     ((wb_is_writereg && wb_is_regdest == 5'(r)) ? 1 : 0);
            if (mdelta < 0 && m_cnt[r] == 0) m_err = 1'b1;
            else m_cnt[r] += mdelta;
         end
         if (!(m_hold.valid && !md)) m_hold = id_in;
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      chk("stall", is_if_stall, m_stall());
      chk("ex_valid", is_ex_valid, m_exv);
      chk("sb_error", is_sb_error, m_err);
      if (m_hold.valid) chk("rd_addr", {is_reg_addra, is_reg_addrb}, {m_hold.addra, m_hold.addrb});
      if (m_exv) begin
         chk("ex_ctl",
             {is_ex_selalushift, is_ex_selimregb, is_ex_unsig, is_ex_readmem, is_ex_writemem,
              is_ex_selwsource, is_ex_writereg, is_ex_writeov, is_ex_aluop, is_ex_shiftop,
              is_ex_regdest, is_ex_shiftamt},
             {m_ex.selalushift, m_ex.selimregb, m_ex.unsig, m_ex.readmem, m_ex.writemem,
              m_ex.selwsource, m_ex.writereg, m_ex.writeov, m_ex.aluop, m_ex.shiftop,
              m_ex.regdest, m_shamt});
         chk("ex_imm", is_ex_imedext, m_ex.imedext);
         chk("ex_rega", is_ex_rega, m_rega);
         chk("ex_regb", is_ex_regb, m_regb);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic drive(input logic [4:0] ra, input logic [4:0] rb, input logic [1:0] nop,
                        input logic wr, input logic [4:0] rd, input logic [31:0] imm);
      id_in.valid       = 1'b1;
      id_in.addra       = ra;
      id_in.addrb       = rb;
      id_in.numop       = nop;
      id_in.writereg    = wr;
      id_in.regdest     = rd;
      id_in.selalushift = imm[0];
      id_in.selimregb   = imm[1];
      id_in.unsig       = imm[2];
      id_in.readmem     = imm[3];
      id_in.writemem    = imm[4];
      id_in.selwsource  = imm[5];
      id_in.writeov     = imm[6];
      id_in.shiftop     = imm[8:7];
      id_in.aluop       = imm[11:9];
      id_in.imedext     = imm;
   endtask

   task automatic bubble();
      id_in.valid = 1'b0;
   endtask

   task automatic wb(input logic [4:0] rd, input logic [31:0] data);
      wb_is_writereg = 1'b1;
      wb_is_regdest  = rd;
      wb_data        = data;
   endtask

   task automatic wb_off();
      wb_is_writereg = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      #1 reset = 1'b0;
      @(negedge clock);
      chk("reset_stall", is_if_stall, 1'b0);
      chk("reset_exv", is_ex_valid, 1'b0);
      chk("reset_bundle", {is_ex_rega, is_ex_regdest, is_ex_aluop}, 40'h0);
      tick();
      reset = 1'b1;

      // Reset while an instruction is stalled on r5
      drive(5'd1, 5'd2, 2'd2, 1'b1, 5'd5, 32'h0000_0F35);
      tick();
      drive(5'd5, 5'd0, 2'd1, 1'b1, 5'd6, 32'h0000_0A5A);
      tick();
      bubble();
      tick();
      @(negedge clock);
      chk("pre_reset_stall", is_if_stall, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("async_reset_stall", is_if_stall, 1'b0);
      chk("async_reset_exv", is_ex_valid, 1'b0);
      chk("async_reset_rega", is_ex_rega, 32'h0);
      ticks(2);
      reset = 1'b1;
      drive(5'd5, 5'd0, 2'd1, 1'b1, 5'd8, 32'h0000_0155);
      tick();
      bubble();
      @(negedge clock);
      chk("post_reset_nostall", is_if_stall, 1'b0);
      tick();
      @(negedge clock);
      chk("post_reset_disp", {is_ex_valid, is_ex_regdest}, {1'b1, 5'd8});

      // Independent back-to-back stream
      tick();
      drive(5'd1, 5'd2, 2'd2, 1'b1, 5'd3, 32'h1234_0001);
      tick();
      drive(5'd1, 5'd2, 2'd2, 1'b1, 5'd4, 32'h0000_0ACE);
      tick();
      bubble();
      @(negedge clock);
      chk("stream_first", {is_ex_valid, is_ex_regdest}, {1'b1, 5'd3});
      tick();
      @(negedge clock);
      chk("stream_second", {is_ex_valid, is_ex_regdest}, {1'b1, 5'd4});
      chk("model_cnt34", {m_cnt[3], m_cnt[4]}, {32'd1, 32'd1});

      // RAW on r3
      tick();
      wb(5'd4, 32'h0000_0044);
      tick();
      wb_off();
      drive(5'd3, 5'd4, 2'd2, 1'b1, 5'd6, 32'h0000_0123);
      tick();
      bubble();
      ticks(2);
      @(negedge clock);
      chk("raw_stall", is_if_stall, 1'b1);
      tick();
      wb(5'd3, 32'h1234_5678);
      tick();
      wb_off();
      @(negedge clock);
      chk("raw_release", is_if_stall, 1'b0);
      tick();
      @(negedge clock);
      chk("raw_rega", is_ex_rega, 32'h1234_5678);
      chk("raw_regb", is_ex_regb, 32'h0000_0044);
      chk("raw_shiftamt", is_ex_shiftamt, 5'h18);

      // Backpressure for three edges
      #1;
      ex_is_ready = 1'b0;
      drive(5'd1, 5'd2, 2'd2, 1'b1, 5'd10, 32'h0000_7777);
      tick();
      bubble();
      @(negedge clock);
      chk("bp_stall", is_if_stall, 1'b1);
      chk("bp_hold1", is_ex_rega, 32'h1234_5678);
      tick();
      @(negedge clock);
      chk("bp_hold2", {is_ex_regdest, is_ex_imedext}, {5'd6, 32'h0000_0123});
      tick();
      @(negedge clock);
      chk("bp_hold3", {is_ex_valid, is_if_stall}, 2'b11);
      #1;
      ex_is_ready = 1'b1;
      tick();
      @(negedge clock);
      chk("bp_release", {is_ex_valid, is_ex_regdest}, {1'b1, 5'd10});

      // Saturation of r7
      tick();
      drive(5'd0, 5'd0, 2'd0, 1'b1, 5'd7, 32'h0000_0071);
      tick();
      drive(5'd0, 5'd0, 2'd0, 1'b1, 5'd7, 32'h0000_0072);
      tick();
      drive(5'd0, 5'd0, 2'd0, 1'b1, 5'd7, 32'h0000_0073);
      tick();
      drive(5'd0, 5'd0, 2'd0, 1'b1, 5'd7, 32'h0000_0074);
      tick();
      bubble();
      @(negedge clock);
      chk("sat_stall", is_if_stall, 1'b1);
      chk("model_cnt7_sat", m_cnt[7], 32'd3);
      tick();
      @(negedge clock);
      chk("sat_stall2", is_if_stall, 1'b1);
      tick();
      wb(5'd7, 32'h7777_0001);
      tick();
      wb_off();
      @(negedge clock);
      chk("sat_release", is_if_stall, 1'b0);
      tick();
      @(negedge clock);
      chk("sat_disp", {is_ex_regdest, is_ex_imedext}, {5'd7, 32'h0000_0074});

      // Same-cycle inc and dec on r7
      tick();
      wb(5'd7, 32'h7777_0002);
      tick();
      wb_off();
      drive(5'd0, 5'd0, 2'd0, 1'b1, 5'd7, 32'h0000_0075);
      tick();
      bubble();
      wb(5'd7, 32'h7777_0003);
      tick();
      wb_off();
      @(negedge clock);
      chk("samecycle_disp", is_ex_imedext, 32'h0000_0075);
      chk("model_cnt7_same", m_cnt[7], 32'd2);
      tick();
      drive(5'd0, 5'd0, 2'd0, 1'b1, 5'd7, 32'h0000_0076);
      tick();
      drive(5'd0, 5'd0, 2'd0, 1'b1, 5'd7, 32'h0000_0077);
      tick();
      bubble();
      @(negedge clock);
      chk("samecycle_cnt_probe", is_if_stall, 1'b1);
      tick();
      wb(5'd7, 32'h7777_0004);
      tick();
      wb_off();
      ticks(2);

      // r0 writers never stall; spurious writebacks
      for (int k = 0; k < 5; k++) begin
         drive(5'd0, 5'd0, 2'd0, 1'b1, 5'd0, 32'h0000_0100 + 32'(k));
         tick();
      end
      bubble();
      @(negedge clock);
      chk("r0_nostall", is_if_stall, 1'b0);
      tick();
      wb(5'd0, 32'hDEAD_0000);
      tick();
      wb_off();
      @(negedge clock);
      chk("wb_r0_noerr", is_sb_error, 1'b0);
      tick();
      wb(5'd9, 32'hDEAD_0009);
      tick();
      wb_off();
      @(negedge clock);
      chk("sb_error_set", is_sb_error, 1'b1);
      ticks(3);
      @(negedge clock);
      chk("sb_error_sticky", is_sb_error, 1'b1);
      #2 reset = 1'b0;
      #1;
      chk("sb_error_reset", is_sb_error, 1'b0);
      ticks(2);
      reset = 1'b1;
      ticks(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
